// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for one shared iterative divider.
// It handles divide-by-zero locally and aborts a divider that never answers.
module div_arbiter #(
    parameter int WIDTH = 4,
    parameter int TMO   = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] y1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             div_go,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             div_clr,
    output logic             rsp_vld,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_err,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             tmo_q, tmo_d;
    logic [WIDTH-1:0] div_x_q, div_x_d, div_y_q, div_y_d;
    logic [WIDTH-1:0] rsp_q_q, rsp_q_d, rsp_r_q, rsp_r_d;
    logic             rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;

    logic             accept;
    logic             sel1;
    logic [WIDTH-1:0] cap_x, cap_y;

    // Handshake: reqN is a level "operation pending"; gntN is the ready and is
    // only offered in IDLE. A cycle with reqN && gntN transfers xN/yN; reqN may
    // then drop and the response still arrives tagged with rsp_id = N.
    assign sel1   = req1 & (~req0 | ~last_q);
    assign accept = (state_q == S_IDLE) & ~rst & (req0 | req1);
    assign gnt0   = accept & ~sel1;
    assign gnt1   = accept & sel1;
    assign cap_x  = sel1 ? x1 : x0;
    assign cap_y  = sel1 ? y1 : y0;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        tmo_d     = tmo_q;
        div_x_d   = div_x_q;
        div_y_d   = div_y_q;
        rsp_q_d   = rsp_q_q;
        rsp_r_d   = rsp_r_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_x_d = cap_x;
                    div_y_d = cap_y;
                    owner_d = sel1;
                    if (cap_y == '0) begin
                        // Divide-by-zero never reaches the divider.
                        rsp_q_d   = '1;
                        rsp_r_d   = cap_x;
                        rsp_err_d = 1'b1;
                        rsp_id_d  = sel1;
                        tmo_d     = 1'b0;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A result on the timeout cycle still counts as a normal result.
                if (div_done) begin
                    rsp_q_d   = div_q;
                    rsp_r_d   = div_r;
                    rsp_err_d = 1'b0;
                    rsp_id_d  = owner_q;
                    tmo_d     = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_q_d   = '0;
                    rsp_r_d   = '0;
                    rsp_err_d = 1'b1;
                    rsp_id_d  = owner_q;
                    tmo_d     = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                tmo_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            tmo_q     <= 1'b0;
            div_x_q   <= '0;
            div_y_q   <= '0;
            rsp_q_q   <= '0;
            rsp_r_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            tmo_q     <= tmo_d;
            div_x_q   <= div_x_d;
            div_y_q   <= div_y_d;
            rsp_q_q   <= rsp_q_d;
            rsp_r_q   <= rsp_r_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign div_go      = (state_q == S_ISSUE);
    assign rsp_vld     = (state_q == S_RESP);
    assign div_clr     = (state_q == S_RESP) & tmo_q;
    assign busy        = (state_q != S_IDLE);
    assign div_x       = div_x_q;
    assign div_y       = div_y_q;
    assign rsp_q       = rsp_q_q;
    assign rsp_r       = rsp_r_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand, quotient and remainder width.
REQ-002 Parameter TMO, default 63: maximum WAIT cycles before abort; valid range 1..255.
REQ-003 clk  in  1  single clock; all logic is clocked on the posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1  requester N has a valid operation pending.
REQ-006 x0, x1  in  WIDTH  dividend of requester N.
REQ-007 y0, y1  in  WIDTH  divisor of requester N.
REQ-008 gnt0, gnt1  out  1  combinational; accepts the operands of requester N this cycle.
REQ-009 div_go  out  1  one-cycle start pulse to the shared divider.
REQ-010 div_x, div_y  out  WIDTH  registered operands to the divider.
REQ-011 div_done  in  1  divider result valid this cycle.
REQ-012 div_q, div_r  in  WIDTH  divider quotient and remainder.
REQ-013 div_clr  out  1  one-cycle pulse that clears the divider after a timeout; ORed externally into the divider rst.
REQ-014 rsp_vld  out  1  one-cycle response pulse.
REQ-015 rsp_id  out  1  requester that owns the response.
REQ-016 rsp_q, rsp_r  out  WIDTH  response quotient and remainder.
REQ-017 rsp_err  out  1  response error (divide-by-zero or timeout).
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; all outputs except gnt0/gnt1 SHALL be registered or decoded from the state (Moore).
REQ-020 Acceptance (IDLE only):
- gntN = reqN AND the arbiter selects N.
- On a grant, capture xN/yN into div_x/div_y, capture N into the owner register, and leave IDLE.
- Requests in any other state SHALL be ignored and SHALL NOT be granted.
REQ-021 Arbitration:
- Exactly one gnt per accept.
- Round-robin: when both requests are high, grant the requester not served last.
- The last-served pointer SHALL reset to 1, so req0 wins the first tie.
- A lone request SHALL be granted regardless of the pointer.
REQ-022 IDLE->ISSUE on a grant with captured divisor != 0.
REQ-023 Divide-by-zero: IDLE->RESP on a grant with captured divisor == 0; div_go SHALL NOT be issued; response is rsp_err=1, rsp_q=all ones, rsp_r=dividend.
REQ-024 ISSUE: div_go=1 for exactly this cycle; ISSUE->WAIT unconditionally.
REQ-025 WAIT:
- A WIDTH-independent 8-bit counter SHALL clear on entry and increment each WAIT cycle.
- On div_done=1, capture div_q/div_r with rsp_err=0; WAIT->RESP.
- div_done seen in any state other than WAIT SHALL be ignored.
REQ-026 Timeout: if the counter reaches TMO with div_done=0, WAIT->RESP with rsp_err=1, rsp_q=0, rsp_r=0, and div_clr=1 during the RESP cycle.
- div_done arriving in the same cycle as the timeout SHALL win: normal result, no div_clr.
REQ-027 RESP:
- rsp_vld=1 for exactly one cycle, with rsp_id=owner.
- Update the last-served pointer to owner; RESP->IDLE.
REQ-028 rsp_q, rsp_r, rsp_err and rsp_id SHALL hold their values until the next RESP.
REQ-029 div_x and div_y SHALL stay stable from the accept cycle until the return to IDLE.
REQ-030 Back-to-back: a requester that still holds req in the IDLE cycle after RESP is a new operation; minimum accept-to-accept spacing is 4 cycles plus divider latency.
REQ-031 A requester that drops req after its grant SHALL still receive its response.

Reset
REQ-032 rst=1 at any clock edge SHALL force:
- state IDLE, last-served pointer 1, WAIT counter 0;
- every output and result register to 0.
REQ-033 A reset during ISSUE, WAIT or RESP SHALL abort the operation with no rsp_vld and no div_clr; the divider is reset by the same rst.
REQ-034 While rst=1, gnt0 and gnt1 SHALL be 0.

Verification
REQ-035 WIDTH=4; req0 with x0=13, y0=4; divider model returns div_q=3, div_r=1 after 20 cycles -> gnt0 for 1 cycle, div_go 1 cycle later, rsp_vld with rsp_id=0, q=3, r=1, err=0.
REQ-036 req0 and req1 both high from reset, held for 2 operations each -> grant order 0,1,0,1; every response carries the matching rsp_id.
REQ-037 req1 with x1=9, y1=0 -> no div_go; rsp_vld 1 cycle after the grant, rsp_id=1, q=15, r=9, err=1.
REQ-038 TMO=5, divider never asserts done -> rsp_err=1, q=0, r=0, div_clr pulses in the RESP cycle; the next operation completes normally.
REQ-039 rst asserted 3 cycles into WAIT -> no rsp_vld, all outputs 0 next cycle; a req1-only request afterwards is granted immediately.
REQ-040 div_done coincident with the timeout cycle, plus spurious div_done pulses in IDLE -> normal result, no div_clr; spurious pulses cause no state change.
